// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the 80x25 text-mode renderer. It holds the screen
//   geometry, the underline-cursor start line, the attribute byte layout and
//   the 16-entry CGA palette. It also provides a lookup helper that turns a
//   palette index into a packed {R,G,B} 12-bit colour.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COLS    = 80;   // text columns, 8 px per cell
    localparam int ROWS    = 25;   // text rows, 16 px per cell
    localparam int CUR_TOP = 14;   // underline cursor covers glyph lines 14..15

    // Attribute byte layout: blink at bit 7, background at [6:4], foreground at [3:0]
    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    // CGA palette in {R,G,B} nibbles. Element 0 is the least-significant slice.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,
        12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    function automatic logic [11:0] pal12(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/vga_palette.sv
// ---------------------------------------------------------------------------
// vga_palette
//   Purely combinational lookup from a 4-bit colour index to 4-bit R, G and B.
//   Ports:
//     i_idx  in  4  palette index 0..15
//     o_r    out 4  red channel
//     o_g    out 4  green channel
//     o_b    out 4  blue channel
// ---------------------------------------------------------------------------
module vga_palette
    import vga_pkg::*;
(
    input  logic [3:0] i_idx,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b
);

    assign {o_r, o_g, o_b} = pal12(i_idx);

endmodule

// File: rtl/vga_text_render.sv
// ---------------------------------------------------------------------------
// vga_text_render
//   80x25 text-mode pixel generator for the 640x400 visible window. It uses
//   a three-stage pipeline:
//     - the cell address goes to video RAM;
//     - the char and line go to font ROM;
//     - the glyph bit goes through the palette to the RGB register.
//   The RAMs return data in the cycle after their (registered) address, so
//   pixel output lags the X/Y inputs by exactly three clock edges.
//   Ports:
//     i_clk        in  1   pixel clock
//     i_rst        in  1   synchronous active-high reset
//     i_de         in  1   X/Y inside the visible window
//     i_x          in  10  pixel column 0..639
//     i_y          in  10  pixel line 0..399
//     i_frame      in  1   once-per-frame pulse, advances blink counter
//     i_cursor     in  11  cursor cell index row*80+col
//     i_cursor_en  in  1   cursor enable
//     o_vram_a     out 11  video RAM cell address
//     i_vram_d     in  16  {attr, char} for o_vram_a
//     o_font_a     out 12  {char, glyph line}
//     i_font_d     in  8   glyph row, bit 7 leftmost
//     o_pix_r/g/b  out 4   pixel colour
//     o_de_out     out 1   i_de delayed to align with o_pix_*
// ---------------------------------------------------------------------------
module vga_text_render
    import vga_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_de,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic        i_frame,
    input  logic [10:0] i_cursor,
    input  logic        i_cursor_en,
    output logic [10:0] o_vram_a,
    input  logic [15:0] i_vram_d,
    output logic [11:0] o_font_a,
    input  logic [7:0]  i_font_d,
    output logic [3:0]  o_pix_r,
    output logic [3:0]  o_pix_g,
    output logic [3:0]  o_pix_b,
    output logic        o_de_out
);

    // Cell index row*80 + col as a shift-add. Bit 9 of Y is always 0 inside the
    // 400-line window, so using Y[9:4] as the row gives the same address.
    logic [10:0] w_row;
    logic [10:0] w_cell;
    logic        w_hit;

    assign w_row  = {5'd0, i_y[9:4]};
    assign w_cell = (w_row << 6) + (w_row << 4) + {4'd0, i_x[9:3]};
    assign w_hit  = i_cursor_en && (w_cell == i_cursor);

    logic [4:0]  r_frame_cnt;

    logic        r_vld_p0;
    logic [2:0]  r_xph_p0;
    logic [3:0]  r_line_p0;
    logic        r_hit_p0;

    logic        r_vld_p1;
    logic [2:0]  r_xph_p1;
    logic        r_cur_p1;
    attr_t       r_attr_p1;

    logic        w_bit;
    logic [3:0]  w_idx;
    logic [3:0]  w_r;
    logic [3:0]  w_g;
    logic [3:0]  w_b;

    // Index priority: cursor underline, then blink-to-background, then glyph bit.
    always_comb begin
        w_bit = i_font_d[3'd7 - r_xph_p1];
        w_idx = w_bit ? r_attr_p1.fg : {1'b0, r_attr_p1.bg};
        if (r_attr_p1.blink && r_frame_cnt[4]) begin
            w_idx = {1'b0, r_attr_p1.bg};
        end
        if (r_cur_p1 && !r_frame_cnt[3]) begin
            w_idx = r_attr_p1.fg;
        end
    end

    vga_palette u_palette (
        .i_idx (w_idx),
        .o_r   (w_r),
        .o_g   (w_g),
        .o_b   (w_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
            o_vram_a    <= '0;
            r_vld_p0    <= 1'b0;
            r_xph_p0    <= '0;
            r_line_p0   <= '0;
            r_hit_p0    <= 1'b0;
            o_font_a    <= '0;
            r_vld_p1    <= 1'b0;
            r_xph_p1    <= '0;
            r_cur_p1    <= 1'b0;
            r_attr_p1   <= '0;
            o_pix_r     <= '0;
            o_pix_g     <= '0;
            o_pix_b     <= '0;
            o_de_out    <= 1'b0;
        end else begin
            if (i_frame) begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end

            // Stage 0: cell address out to video RAM, capture pixel position
            o_vram_a  <= w_cell;
            r_vld_p0  <= i_de;
            r_xph_p0  <= i_x[2:0];
            r_line_p0 <= i_y[3:0];
            r_hit_p0  <= w_hit;

            // Stage 1: glyph address out to font ROM, capture attribute
            o_font_a  <= {i_vram_d[7:0], r_line_p0};
            r_attr_p1 <= attr_t'(i_vram_d[15:8]);
            r_vld_p1  <= r_vld_p0;
            r_xph_p1  <= r_xph_p0;
            r_cur_p1  <= r_hit_p0 && (r_line_p0 >= 4'(CUR_TOP));

            // Stage 2: colour out, blanked outside the visible window
            o_pix_r  <= r_vld_p1 ? w_r : 4'h0;
            o_pix_g  <= r_vld_p1 ? w_g : 4'h0;
            o_pix_b  <= r_vld_p1 ? w_b : 4'h0;
            o_de_out <= r_vld_p1;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// ---------------------------------------------------------------------------
// tb_vga_text_render
//   Directed bench for the text renderer. Video RAM and font ROM are arrays
//   read through the DUT's registered address outputs. Their data therefore
//   arrives one cycle after the address that the DUT computed.
// ---------------------------------------------------------------------------
module tb_vga_text_render;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame;
    logic [10:0] cursor;
    logic        cursor_en;
    logic [10:0] vram_a;
    logic [15:0] vram_d;
    logic [11:0] font_a;
    logic [7:0]  font_d;
    logic [3:0]  pix_r;
    logic [3:0]  pix_g;
    logic [3:0]  pix_b;
    logic        de_out;

    logic [15:0] vram [0:2047];
    logic [7:0]  font [0:4095];

    assign vram_d = vram[vram_a];
    assign font_d = font[font_a];

    vga_text_render dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_de        (de),
        .i_x         (x),
        .i_y         (y),
        .i_frame     (frame),
        .i_cursor    (cursor),
        .i_cursor_en (cursor_en),
        .o_vram_a    (vram_a),
        .i_vram_d    (vram_d),
        .o_font_a    (font_a),
        .i_font_d    (font_d),
        .o_pix_r     (pix_r),
        .o_pix_g     (pix_g),
        .o_pix_b     (pix_b),
        .o_de_out    (de_out)
    );

    typedef struct {
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [10:0] cur;
        logic        cur_en;
        logic [11:0] exp_rgb;
        logic        exp_de;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input int px, input int py, input int cur,
                       input logic cen, input logic [11:0] rgb, input logic ed,
                       input string name);
        vec_t v;
        v.de = d; v.x = 10'(px); v.y = 10'(py); v.cur = 11'(cur); v.cur_en = cen;
        v.exp_rgb = rgb; v.exp_de = ed; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic d, input int px, input int py, input int cur, input logic cen);
        de = d; x = 10'(px); y = 10'(py); cursor = 11'(cur); cursor_en = cen;
    endtask

    // Hold one input set for three edges, then compare the pixel it produced.
    task automatic check_px(input string name, input logic d, input int px, input int py,
                            input int cur, input logic cen, input logic [11:0] rgb, input logic ed);
        drive(d, px, py, cur, cen);
        tick(); tick(); tick();
        chk({name, "_rgb"}, {20'd0, pix_r, pix_g, pix_b}, {20'd0, rgb});
        chk({name, "_de"}, {31'd0, de_out}, {31'd0, ed});
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) font[i] = 8'h00;
        vram[0]    = 16'h1F41;                     // 'A', white on blue
        font[{8'h41, 4'h0}] = 8'h18;
        vram[1999] = 16'h4E7C;                     // yellow on red, last cell
        font[{8'h7C, 4'hF}] = 8'h01;
        vram[81]   = 16'h0E00;                     // blank glyph, yellow fg
        vram[2]    = 16'h87DB;                     // blinking grey solid block
        for (int l = 0; l < 16; l++) font[{8'hDB, 4'(l)}] = 8'hFF;

        rst = 1'b1; frame = 1'b0;
        drive(1'b0, 0, 0, 81, 1'b0);
        tick(); tick();
        chk("rst_pix", {20'd0, pix_r, pix_g, pix_b}, 32'h0);
        chk("rst_de", {31'd0, de_out}, 32'h0);
        chk("rst_vram_a", {21'd0, vram_a}, 32'h0);
        chk("rst_font_a", {20'd0, font_a}, 32'h0);
        rst = 1'b0;

        // Frame counter is 0 here: no blink, cursor phase on.
        for (int i = 0; i < 8; i++)
            add(1'b1, i, 0, 81, 1'b0, (i == 3 || i == 4) ? 12'hFFF : 12'h00A, 1'b1, $sformatf("glyphA_x%0d", i));
        add(1'b0, 3, 0, 81, 1'b0, 12'h000, 1'b0, "de_low_fg");
        add(1'b0, 639, 399, 81, 1'b0, 12'h000, 1'b0, "de_low_last");
        add(1'b1, 639, 399, 81, 1'b0, 12'hFF5, 1'b1, "last_px_fg");
        add(1'b1, 632, 399, 81, 1'b0, 12'hA00, 1'b1, "last_cell_bg");
        for (int i = 8; i < 16; i++)
            add(1'b1, i, 30, 81, 1'b1, 12'hFF5, 1'b1, $sformatf("cursor_x%0d", i));
        add(1'b1, 8, 29, 81, 1'b1, 12'h000, 1'b1, "cursor_line13");
        add(1'b1, 15, 31, 81, 1'b1, 12'hFF5, 1'b1, "cursor_line15");
        add(1'b1, 8, 30, 81, 1'b0, 12'h000, 1'b1, "cursor_off");
        add(1'b1, 16, 0, 81, 1'b0, 12'hAAA, 1'b1, "blink_cnt0_a");
        add(1'b1, 23, 15, 81, 1'b0, 12'hAAA, 1'b1, "blink_cnt0_b");

        // Back-to-back stream: vector j comes out after the third edge following it.
        for (int j = 0; j < vecs.size() + 2; j++) begin
            if (j < vecs.size())
                drive(vecs[j].de, int'(vecs[j].x), int'(vecs[j].y), int'(vecs[j].cur), vecs[j].cur_en);
            tick();
            if (j >= 2) begin
                chk({vecs[j-2].name, "_rgb"}, {20'd0, pix_r, pix_g, pix_b}, {20'd0, vecs[j-2].exp_rgb});
                chk({vecs[j-2].name, "_de"}, {31'd0, de_out}, {31'd0, vecs[j-2].exp_de});
            end
        end

        // Address timing at the bottom-right corner.
        drive(1'b1, 639, 399, 81, 1'b0);
        tick();
        chk("corner_vram_a", {21'd0, vram_a}, 32'd1999);
        tick();
        chk("corner_font_a", {20'd0, font_a}, {20'd0, 8'h7C, 4'hF});
        tick();
        chk("corner_pix", {20'd0, pix_r, pix_g, pix_b}, 32'hFF5);

        // Blink and cursor phases across the frame counter.
        frames(8);
        check_px("cnt8_cursor", 1'b1, 8, 30, 81, 1'b1, 12'h000, 1'b1);
        check_px("cnt8_blink", 1'b1, 16, 0, 81, 1'b0, 12'hAAA, 1'b1);
        frames(8);
        check_px("cnt16_blink", 1'b1, 16, 0, 81, 1'b0, 12'h000, 1'b1);
        check_px("cnt16_cursor", 1'b1, 8, 30, 81, 1'b1, 12'hFF5, 1'b1);
        frames(16);
        check_px("cnt0_wrap_blink", 1'b1, 16, 0, 81, 1'b0, 12'hAAA, 1'b1);

        // Mid-line reset with a simultaneous frame pulse; counter at 7 beforehand.
        frames(7);
        check_px("pre_rst_cursor", 1'b1, 8, 30, 81, 1'b1, 12'hFF5, 1'b1);
        rst = 1'b1; frame = 1'b1;
        tick();
        rst = 1'b0; frame = 1'b0;
        chk("mid_rst_vram_a", {21'd0, vram_a}, 32'h0);
        chk("mid_rst_font_a", {20'd0, font_a}, 32'h0);
        for (int e = 0; e < 3; e++) begin
            chk($sformatf("mid_rst_pix_e%0d", e), {20'd0, pix_r, pix_g, pix_b}, 32'h0);
            chk($sformatf("mid_rst_de_e%0d", e), {31'd0, de_out}, 32'h0);
            tick();
        end
        chk("post_rst_pix", {20'd0, pix_r, pix_g, pix_b}, 32'hFF5);
        chk("post_rst_de", {31'd0, de_out}, 32'h1);
        frames(8);
        check_px("post_rst_cnt8", 1'b1, 8, 30, 81, 1'b1, 12'h000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
